// File: rtl/branch_update_queue_pkg.sv
// Shared types and defaults for the branch update queue.
// Entries carry the committed branch PC and its resolved direction.
package branch_update_queue_pkg;

    localparam int BU_QUEUE_DEPTH = 4;
    localparam int BU_PTR_BIT     = 2;
    localparam int BU_CNT_BIT     = 32;
    localparam int ADDR_W         = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  jump;
    } bu_entry_t;

    localparam int ENTRY_W = $bits(bu_entry_t);

endpackage

// File: rtl/branch_update_queue_fifo_core.sv
// Circular buffer with registered full/empty; head entry read combinationally.
// Push visible one edge later; pushes while full and pops while empty are ignored.
module bu_fifo_core
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH   = BU_QUEUE_DEPTH,
    parameter int PTR_BIT = BU_PTR_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld,
    input  logic [ENTRY_W-1:0] push_dat,
    input  logic               pop_rdy,
    output logic [ENTRY_W-1:0] head_dat,
    output logic               full,
    output logic               empty
);

    localparam logic [PTR_BIT:0] DEPTH_CNT = (PTR_BIT+1)'(DEPTH);

    logic [PTR_BIT-1:0] head_q, head_d;
    logic [PTR_BIT-1:0] tail_q, tail_d;
    logic [PTR_BIT:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    bu_entry_t          mem_q [DEPTH];
    bu_entry_t          mem_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign push_ok = push_vld && !full_q;
    assign pop_ok  = pop_rdy && !empty_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (push_ok) begin
            mem_d[tail_q] = bu_entry_t'(push_dat);
            tail_d        = tail_q + 1'b1;
        end
        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flags are registered from the next count so full/empty never see pop_rdy.
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[head_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/branch_update_queue.sv
// Queues committed branch outcomes for the predictor and keeps branch/mispredict stats.
// Entry usable one edge after commit; full_to_rob stalls commit, pdt_ready drains one per cycle.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH   = BU_QUEUE_DEPTH,
    parameter int QUEUE_PTR_BIT = BU_PTR_BIT,
    parameter int CNT_BIT       = BU_CNT_BIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid_from_rob,
    input  logic [31:0]        commit_pc_from_rob,
    input  logic               commit_jump_from_rob,
    input  logic               commit_mispredict_from_rob,
    output logic               full_to_rob,
    input  logic               pdt_ready,
    output logic               enable_sign_to_pdt,
    output logic               jump_sign_to_pdt,
    output logic [31:0]        jump_target_pc_to_pdt,
    output logic               overflow_flag,
    output logic [CNT_BIT-1:0] branch_cnt,
    output logic [CNT_BIT-1:0] mispredict_cnt
);

    bu_entry_t push_ent;
    bu_entry_t head_ent;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      push_acc;

    logic               overflow_q, overflow_d;
    logic [CNT_BIT-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_BIT-1:0] mispredict_cnt_q, mispredict_cnt_d;

    assign push_ent.pc   = commit_pc_from_rob;
    assign push_ent.jump = commit_jump_from_rob;

    assign push_acc = commit_valid_from_rob && !fifo_full;
    assign fifo_pop = enable_sign_to_pdt && pdt_ready;

    bu_fifo_core #(
        .DEPTH   (QUEUE_DEPTH),
        .PTR_BIT (QUEUE_PTR_BIT)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (commit_valid_from_rob),
        .push_dat (push_ent),
        .pop_rdy  (fifo_pop),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        overflow_d       = overflow_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        // A commit while full is lost even if the head drains this cycle.
        if (commit_valid_from_rob && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (push_acc) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
            if (commit_mispredict_from_rob) begin
                mispredict_cnt_d = mispredict_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            overflow_q       <= overflow_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Storage is not reset, so head data is masked while nothing is queued.
    assign enable_sign_to_pdt    = !fifo_empty;
    assign jump_sign_to_pdt      = fifo_empty ? 1'b0 : head_ent.jump;
    assign jump_target_pc_to_pdt = fifo_empty ? 32'h0 : head_ent.pc;
    assign full_to_rob           = fifo_full;
    assign overflow_flag         = overflow_q;
    assign branch_cnt            = branch_cnt_q;
    assign mispredict_cnt        = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: reset, single, fill/overflow, drain, concurrent, stats, counter wrap.
module tb_branch_update_queue;

    logic        clk;
    logic        rst;

    logic        c_vld, c_jump, c_misp, rdy;
    logic [31:0] c_pc;
    logic        full, en, jmp, ovf;
    logic [31:0] pc_o, bcnt, mcnt;

    logic        w_vld, w_jump_in, w_misp, w_rdy;
    logic [31:0] w_pc_in;
    logic        w_full, w_en, w_jmp, w_ovf;
    logic [31:0] w_pc;
    logic [3:0]  w_bcnt, w_mcnt;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    branch_update_queue dut (
        .clk                        (clk),
        .rst                        (rst),
        .commit_valid_from_rob      (c_vld),
        .commit_pc_from_rob         (c_pc),
        .commit_jump_from_rob       (c_jump),
        .commit_mispredict_from_rob (c_misp),
        .full_to_rob                (full),
        .pdt_ready                  (rdy),
        .enable_sign_to_pdt         (en),
        .jump_sign_to_pdt           (jmp),
        .jump_target_pc_to_pdt      (pc_o),
        .overflow_flag              (ovf),
        .branch_cnt                 (bcnt),
        .mispredict_cnt             (mcnt)
    );

    branch_update_queue #(.CNT_BIT(4)) dut_w (
        .clk                        (clk),
        .rst                        (rst),
        .commit_valid_from_rob      (w_vld),
        .commit_pc_from_rob         (w_pc_in),
        .commit_jump_from_rob       (w_jump_in),
        .commit_mispredict_from_rob (w_misp),
        .full_to_rob                (w_full),
        .pdt_ready                  (w_rdy),
        .enable_sign_to_pdt         (w_en),
        .jump_sign_to_pdt           (w_jmp),
        .jump_target_pc_to_pdt      (w_pc),
        .overflow_flag              (w_ovf),
        .branch_cnt                 (w_bcnt),
        .mispredict_cnt             (w_mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        c_vld = 0; c_pc = '0; c_jump = 0; c_misp = 0; rdy = 0;
        w_vld = 0; w_pc_in = '0; w_jump_in = 0; w_misp = 0; w_rdy = 0;
        #1 rst = 1'b1;
        #3;
        chk("rst_en",   en,   0);
        chk("rst_full", full, 0);
        chk("rst_jmp",  jmp,  0);
        chk("rst_pc",   pc_o, 0);
        chk("rst_ovf",  ovf,  0);
        chk("rst_bcnt", bcnt, 0);
        chk("rst_mcnt", mcnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single push with the predictor ready: no same-cycle bypass.
        c_vld = 1; c_pc = 32'h1000; c_jump = 1; rdy = 1;
        tick();
        c_vld = 0;
        chk("single_en",   en,   1);
        chk("single_pc",   pc_o, 32'h1000);
        chk("single_jmp",  jmp,  1);
        tick();
        chk("single_en0",  en,   0);
        chk("single_pc0",  pc_o, 0);
        chk("single_jmp0", jmp,  0);
        chk("single_bcnt", bcnt, 1);

        // Fill with the predictor stalled.
        do_reset();
        rdy = 0;
        for (int i = 0; i < 4; i++) begin
            c_vld = 1; c_pc = 32'h10 + 32'(4*i); c_jump = i[0];
            tick();
            if (i == 2) chk("fill_notfull", full, 0);
        end
        chk("fill_full", full, 1);
        chk("fill_en",   en,   1);
        chk("fill_pc",   pc_o, 32'h10);
        chk("fill_jmp",  jmp,  0);

        // Push while full with a same-cycle pop: push dropped, pop still happens.
        c_pc = 32'h20; c_jump = 1; c_misp = 1; rdy = 1;
        tick();
        c_vld = 0; c_misp = 0;
        chk("ovf_flag", ovf,  1);
        chk("ovf_bcnt", bcnt, 4);
        chk("ovf_mcnt", mcnt, 0);
        chk("ovf_full", full, 0);
        chk("drain_pc1", pc_o, 32'h14);
        chk("drain_j1",  jmp,  1);
        tick();
        chk("drain_pc2", pc_o, 32'h18);
        chk("drain_j2",  jmp,  0);
        tick();
        chk("drain_pc3", pc_o, 32'h1C);
        chk("drain_j3",  jmp,  1);
        tick();
        chk("drain_en0",  en,  0);
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // Concurrent push+pop holding two entries, wrapping the pointers.
        rdy = 0; c_vld = 1; c_jump = 0;
        c_pc = 32'h100; tick();
        c_pc = 32'h104; tick();
        rdy = 1;
        for (int i = 0; i < 10; i++) begin
            c_pc = 32'h108 + 32'(4*i);
            tick();
            chk("conc_pc",   pc_o, 32'h100 + 32'(4*(i+1)));
            chk("conc_full", full, 0);
        end
        c_vld = 0;
        tick();
        chk("conc_tail_pc", pc_o, 32'h12C);
        tick();
        chk("conc_empty", en,   0);
        chk("conc_bcnt",  bcnt, 12);
        do_reset();

        // Mispredict statistics: 6 branches, 3 mispredicted.
        rdy = 1;
        for (int i = 0; i < 6; i++) begin
            c_vld = 1; c_pc = 32'h200 + 32'(4*i);
            c_misp = (i == 0 || i == 2 || i == 5);
            tick();
        end
        c_vld = 0; c_misp = 0;
        chk("stat_mcnt", mcnt, 3);
        chk("stat_bcnt", bcnt, 6);
        chk("stat_en",   en,   1);
        chk("stat_pc",   pc_o, 32'h214);

        // Reset asserted mid-cycle takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk("arst_en",   en,   0);
        chk("arst_full", full, 0);
        chk("arst_pc",   pc_o, 0);
        chk("arst_bcnt", bcnt, 0);
        chk("arst_mcnt", mcnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 4-bit counters wrap from 15 to 0.
        w_rdy = 1; w_misp = 1;
        for (int i = 0; i < 16; i++) begin
            w_vld = 1; w_pc_in = 32'h300 + 32'(i); w_jump_in = i[0];
            tick();
            if (i == 14) begin
                chk("wrap_b15", w_bcnt, 4'hF);
                chk("wrap_m15", w_mcnt, 4'hF);
            end
        end
        w_vld = 0;
        chk("wrap_b0",   w_bcnt, 0);
        chk("wrap_m0",   w_mcnt, 0);
        chk("wrap_en",   w_en,   1);
        chk("wrap_pc",   w_pc,   32'h30F);
        chk("wrap_jmp",  w_jmp,  1);
        chk("wrap_full", w_full, 0);
        chk("wrap_ovf",  w_ovf,  0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
